uart_rx_latch: RTL and testbench

- UART receiver; the receive-side counterpart of the sum/latch UART transmitter.
- Deserialises 8N1 frames from uart_rxd, LSB first, using a per-bit clock counter.
- Holds each received byte in a single-entry holding register with a valid/ack handshake.
- Reports framing errors and overruns; feeds host-side commands back into the latch/sum datapath.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx_latch.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_latch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line constants.
// UART_RX_PARITY_EN adds the PARITY state between DATA and STOP.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 5208;
   localparam int UART_DATA_BITS       = 8;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge pulse.
// All flops reset to the idle-high line level.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rxd,
   output logic rxd_sync,
   output logic fall
);

   logic sync1, sync2, prev;

   // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain shifts one stage per clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= rxd;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rxd_sync = sync2;
   assign fall     = prev & ~sync2;

endmodule

// File: rtl/uart_rx_latch.sv
// UART receiver with a single-entry holding register and valid/ack handshake.
// Define UART_RX_PARITY_EN for an even-parity bit and the rx_parity_err output.
module uart_rx_latch
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 uart_rxd,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
`ifdef UART_RX_PARITY_EN
   ,output logic                rx_parity_err
`endif
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   rx_state_t            state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [2:0]           idx, idx_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic                 rxd_s, fall;
   logic                 stop_sample, frame_bad, good;

   uart_rx_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .rxd      (uart_rxd),
      .rxd_sync (rxd_s),
      .fall     (fall)
   );

`ifdef UART_RX_PARITY_EN
   logic par_bit, par_nxt, par_bad;
`endif

   // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx;
      shift_nxt   = shift;
      stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt     = par_bit;
`endif
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt = START;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         end
         START: begin
            if (cnt == HALF_M1) begin
               cnt_nxt   = '0;
               state_nxt = rxd_s ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_nxt   = '0;
               shift_nxt = {rxd_s, shift[DATA_BITS-1:1]};
               if (idx == LAST_BIT) begin
                  idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == FULL_M1) begin
               cnt_nxt   = '0;
               par_nxt   = rxd_s;
               state_nxt = STOP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            // Leaving at mid-stop-bit gives half a bit of slack to catch the next start edge.
            if (cnt == FULL_M1) begin
               cnt_nxt     = '0;
               stop_sample = 1'b1;
               state_nxt   = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign frame_bad = stop_sample & ~rxd_s;
`ifdef UART_RX_PARITY_EN
   assign par_bad = stop_sample & rxd_s & (par_bit != ^shift);
   assign good    = stop_sample & rxd_s & ~par_bad;
`else
   assign good    = stop_sample & rxd_s;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shift <= shift_nxt;
`ifdef UART_RX_PARITY_EN
         par_bit <= par_nxt;
`endif
      end
   end

   // Holding register: an ack coinciding with a load frees the slot, so it is not an overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_frame_err <= frame_bad;
         rx_overrun   <= good & rx_valid & ~rx_ack;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= par_bad;
`endif
         if (good && (!rx_valid || rx_ack)) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_latch.sv
// Self-checking bench for uart_rx_latch at CLKS_PER_BIT=16: directed sequences,
// a frame table and random frames against a frame-level holding-register model.
module tb_uart_rx_latch;

   localparam int C = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int LAT = 3 + C / 2 + (9 + PBITS) * C;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, rx_frame_err, rx_overrun;
`ifdef UART_RX_PARITY_EN
   logic       rx_parity_err;
`endif

   uart_rx_latch #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .uart_rxd     (rxd),
      .rx_ack       (rx_ack),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_busy      (rx_busy),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
`ifdef UART_RX_PARITY_EN
      ,.rx_parity_err (rx_parity_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;

   always @(negedge clk) begin
      if (!reset) begin
         fe_cnt += int'(rx_frame_err);
         ov_cnt += int'(rx_overrun);
`ifdef UART_RX_PARITY_EN
         pe_cnt += int'(rx_parity_err);
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
      tick(1);
   endtask

   // A low stop bit is left driven; the caller decides how long the line stays low.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
      rxd = 1'b0;
      tick(C);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(C);
      end
`ifdef UART_RX_PARITY_EN
      rxd = par;
      tick(C);
`endif
      rxd = stop;
      tick(C);
      if (stop) rxd = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_fe;
   } vec_t;

   vec_t       vecs[6];
   int         lat, fe0, ov0, pe0, busy_mid;
   logic [7:0] d;
   logic       st;
   logic       m_valid;
   logic [7:0] m_data;
   int         m_fe, m_ov;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      vecs[4] = '{8'h81, 1'b0, 1'b0, 8'hFF, 1};
      vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 0};

      reset = 1'b1; rxd = 1'b1; rx_ack = 1'b0;
      tick(4);
      check("reset_data", rx_data, 8'h00);
      check("reset_valid", rx_valid, 0);
      check("reset_busy", rx_busy, 0);
      check("reset_frame_err", rx_frame_err, 0);
      check("reset_overrun", rx_overrun, 0);
      reset = 1'b0;
      tick(2 * C);

      // 0xA5: latency, busy during the frame, ack clears valid
      lat = 0; busy_mid = 0;
      fork
         send_frame(8'hA5, 1'b1, ^8'hA5);
         begin
            while (!rx_valid && lat < 400) begin
               tick(1);
               lat++;
               if (lat == 80) busy_mid = int'(rx_busy);
            end
         end
      join
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         failures++;
         $display("FAIL a5_latency actual=%0d required=%0d(+-1)", lat, LAT);
      end
      check("a5_busy_mid", busy_mid, 1);
      check("a5_data", rx_data, 8'hA5);
      check("a5_valid", rx_valid, 1);
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
      check("a5_ack_clears", rx_valid, 0);
      check("a5_idle_busy", rx_busy, 0);
      tick(C);

      // 4-cycle glitch on an idle line
      fe0 = fe_cnt; ov0 = ov_cnt;
      rxd = 1'b0; tick(4); rxd = 1'b1; tick(2 * C);
      check("glitch_valid", rx_valid, 0);
      check("glitch_busy", rx_busy, 0);
      check("glitch_frame_err", fe_cnt - fe0, 0);
      check("glitch_overrun", ov_cnt - ov0, 0);

      // bad stop bit, line then held low: no restart without a fresh edge
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, ^8'h3C);
      tick(30);
      check("break_busy", rx_busy, 0);
      tick(10);
      rxd = 1'b1;
      tick(C);
      check("ferr_pulses", fe_cnt - fe0, 1);
      check("ferr_valid", rx_valid, 0);
      check("ferr_busy", rx_busy, 0);

      // back-to-back without ack -> overrun, first byte kept
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1, ^8'h11);
      send_frame(8'h22, 1'b1, ^8'h22);
      tick(C);
      check("ovr_data", rx_data, 8'h11);
      check("ovr_valid", rx_valid, 1);
      check("ovr_pulses", ov_cnt - ov0, 1);
      pulse_ack();
      send_frame(8'h33, 1'b1, ^8'h33);
      tick(C);
      check("after_ovr_data", rx_data, 8'h33);
      check("after_ovr_valid", rx_valid, 1);

      // reset in the middle of 0xFF's data bits
      rxd = 1'b0; tick(C);
      rxd = 1'b1; tick(3 * C);
      reset = 1'b1; tick(1); reset = 1'b0;
      check("midrst_data", rx_data, 8'h00);
      check("midrst_valid", rx_valid, 0);
      check("midrst_busy", rx_busy, 0);
      check("midrst_frame_err", rx_frame_err, 0);
      check("midrst_overrun", rx_overrun, 0);
      tick((6 + PBITS) * C);
      send_frame(8'h5A, 1'b1, ^8'h5A);
      tick(C);
      check("post_rst_data", rx_data, 8'h5A);
      check("post_rst_valid", rx_valid, 1);

      // ack in the same cycle as the next load: new byte, no overrun
      ov0 = ov_cnt;
      fork
         send_frame(8'hC3, 1'b1, ^8'hC3);
         begin
            tick(LAT - 1);
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
         end
      join
      tick(C);
      check("same_cycle_data", rx_data, 8'hC3);
      check("same_cycle_valid", rx_valid, 1);
      check("same_cycle_overrun", ov_cnt - ov0, 0);

      // frame table
      foreach (vecs[i]) begin
         fe0 = fe_cnt; ov0 = ov_cnt;
         pulse_ack();
         send_frame(vecs[i].data, vecs[i].stop_bit, ^vecs[i].data);
         if (!vecs[i].stop_bit) begin
            tick(40);
            rxd = 1'b1;
         end
         tick(C);
         check($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
         check($sformatf("vec%0d_ferr", i), fe_cnt - fe0, vecs[i].exp_fe);
         check($sformatf("vec%0d_ovr", i), ov_cnt - ov0, 0);
      end

`ifdef UART_RX_PARITY_EN
      pe0 = pe_cnt;
      pulse_ack();
      send_frame(8'h07, 1'b1, 1'b1);
      tick(C);
      check("par_ok_valid", rx_valid, 1);
      check("par_ok_data", rx_data, 8'h07);
      check("par_ok_perr", pe_cnt - pe0, 0);
      pulse_ack();
      fe0 = fe_cnt;
      send_frame(8'h07, 1'b1, 1'b0);
      tick(C);
      check("par_bad_valid", rx_valid, 0);
      check("par_bad_perr", pe_cnt - pe0, 1);
      check("par_bad_ferr", fe_cnt - fe0, 0);
`endif

      // random frames against a frame-level model of the holding register
      pulse_ack();
      m_valid = 1'b0; m_data = rx_data;
      m_fe = fe_cnt; m_ov = ov_cnt;
      m_data = vecs[5].exp_data;
      for (int i = 0; i < 24; i++) begin
         d  = 8'($urandom);
         st = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            pulse_ack();
            m_valid = 1'b0;
         end
         send_frame(d, st, ^d);
         if (!st) begin
            tick($urandom_range(0, 20));
            rxd = 1'b1;
         end
         tick(C);
         if (!st) m_fe++;
         else if (m_valid) m_ov++;
         else begin
            m_valid = 1'b1;
            m_data  = d;
         end
         check($sformatf("rnd%0d_valid", i), rx_valid, m_valid);
         check($sformatf("rnd%0d_data", i), rx_data, m_data);
         check($sformatf("rnd%0d_ferr", i), fe_cnt, m_fe);
         check($sformatf("rnd%0d_ovr", i), ov_cnt, m_ov);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
